// File: rtl/lg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lg_arb_pkg
// Purpose  : Shared types and constants for the life-game cell RAM arbiter.
//            Requester ID encoding, default bus widths, stall counter width.
// Options  : none (LG_ARB_PERF_EN is consumed by lg_cell_arbiter)
// Revision : 1.0 - initial release
// ============================================================================
package lg_arb_pkg;

    localparam int C_ADDR_W  = 7;   // cell word address width (128 words)
    localparam int C_DATA_W  = 32;  // cell word width
    localparam int C_STALL_W = 16;  // width of each stall counter

    // Requester ID carried through the tag pipeline
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_VGA  = 2'd1,
        REQ_CPU  = 2'd2,
        REQ_ENG  = 2'd3
    } req_id_e;

endpackage : lg_arb_pkg
`default_nettype wire

// File: rtl/lg_cell_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : lg_cell_arbiter_if
// Purpose  : Bundles the three requester handshakes and the cell RAM port.
// Ports    : vga_*  VGA read requester   (req/addr -> ack/rdata)
//            cpu_*  CPU requester        (req/we/addr/wdata -> ack/rdata)
//            eng_*  engine requester     (req/we/addr/wdata -> ack/rdata)
//            mem_*  RAM port             (en/we/addr/wdata -> rdata)
// Modports : slave  - arbiter side
//            master - requesters + RAM side
// Revision : 1.0 - initial release
// ============================================================================
interface lg_cell_arbiter_if
    import lg_arb_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic [DATA_W-1:0] vga_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              eng_req;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_wdata;
    logic              eng_ack;
    logic [DATA_W-1:0] eng_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vga_req, vga_addr,
        output vga_ack, vga_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  eng_req, eng_we, eng_addr, eng_wdata,
        output eng_ack, eng_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output vga_req, vga_addr,
        input  vga_ack, vga_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output eng_req, eng_we, eng_addr, eng_wdata,
        input  eng_ack, eng_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface : lg_cell_arbiter_if
`default_nettype wire

// File: rtl/lg_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : lg_arb_pick
// Purpose  : Combinational winner select for the cell RAM arbiter.
//            VGA has absolute priority; CPU and engine alternate on a tie,
//            preferring the one that did not win last.
// Ports    : elig    [2:0] eligible vector {ENG, CPU, VGA}
//            rr_last       last CPU/engine winner
//            winner        selected requester ID (REQ_NONE if none)
// Revision : 1.0 - initial release
// ============================================================================
module lg_arb_pick
    import lg_arb_pkg::*;
(
    input  wire logic [2:0] elig,
    input  req_id_e         rr_last,
    output req_id_e         winner
);

    always_comb begin
        winner = REQ_NONE;
        if (elig[0]) begin
            winner = REQ_VGA;
        end else if (elig[1] && elig[2]) begin
            winner = (rr_last == REQ_CPU) ? REQ_ENG : REQ_CPU;
        end else if (elig[1]) begin
            winner = REQ_CPU;
        end else if (elig[2]) begin
            winner = REQ_ENG;
        end
    end

endmodule : lg_arb_pick
`default_nettype wire

// File: rtl/lg_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lg_cell_arbiter
// Purpose  : Arbitrates the single-port life-game cell RAM between the VGA
//            reader, the CPU and the world-update engine. A three-stage tag
//            pipeline (issue / RAM read / ack) tracks accesses in flight;
//            each requester has at most one access outstanding.
// Ports    : clk       RAM-domain clock, rising edge
//            rst       asynchronous active-high reset
//            bus       lg_cell_arbiter_if.slave (requesters + RAM port)
//            perf_clr  (LG_ARB_PERF_EN) synchronous clear of stall counters
//            *_stall   (LG_ARB_PERF_EN) saturating per-requester stall counts
// Options  : LG_ARB_PERF_EN - adds the stall counters and their ports
// Revision : 1.0 - initial release
// ============================================================================
module lg_cell_arbiter
    import lg_arb_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
)(
    input  wire logic                 clk,
    input  wire logic                 rst,
`ifdef LG_ARB_PERF_EN
    input  wire logic                 perf_clr,
    output logic      [C_STALL_W-1:0] vga_stall,
    output logic      [C_STALL_W-1:0] cpu_stall,
    output logic      [C_STALL_W-1:0] eng_stall,
`endif
    lg_cell_arbiter_if.slave          bus
);

    // Tag pipeline and round-robin state
    req_id_e           r_tag_a;
    req_id_e           r_tag_b;
    req_id_e           r_tag_c;
    logic              r_we_b;     // write flag travelling with r_tag_b
    req_id_e           r_rr;

    // Registered RAM port
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // Registered completions
    logic              r_vga_ack;
    logic              r_cpu_ack;
    logic              r_eng_ack;
    logic [DATA_W-1:0] r_vga_rdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_eng_rdata;

    logic [2:0]        w_elig;
    logic [2:0]        w_win_oh;
    req_id_e           w_winner;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    function automatic logic in_flight(input req_id_e id, input req_id_e a,
                                       input req_id_e b, input req_id_e c);
        return (a == id) || (b == id) || (c == id);
    endfunction

    // A requester still anywhere in the pipeline (including its ack cycle)
    // is not eligible, which enforces one outstanding access each.
    always_comb begin
        w_elig[0] = bus.vga_req && !in_flight(REQ_VGA, r_tag_a, r_tag_b, r_tag_c);
        w_elig[1] = bus.cpu_req && !in_flight(REQ_CPU, r_tag_a, r_tag_b, r_tag_c);
        w_elig[2] = bus.eng_req && !in_flight(REQ_ENG, r_tag_a, r_tag_b, r_tag_c);
    end

    lg_arb_pick u_pick (
        .elig    (w_elig),
        .rr_last (r_rr),
        .winner  (w_winner)
    );

    assign w_win_oh = {w_winner == REQ_ENG, w_winner == REQ_CPU, w_winner == REQ_VGA};

    // Winner's command; address/data fall back to current values when idle
    always_comb begin
        w_we    = 1'b0;
        w_addr  = r_mem_addr;
        w_wdata = r_mem_wdata;
        case (w_winner)
            REQ_VGA: begin
                w_addr  = bus.vga_addr;
                w_wdata = '0;
            end
            REQ_CPU: begin
                w_we    = bus.cpu_we;
                w_addr  = bus.cpu_addr;
                w_wdata = bus.cpu_wdata;
            end
            REQ_ENG: begin
                w_we    = bus.eng_we;
                w_addr  = bus.eng_addr;
                w_wdata = bus.eng_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_a     <= REQ_NONE;
            r_tag_b     <= REQ_NONE;
            r_tag_c     <= REQ_NONE;
            r_we_b      <= 1'b0;
            r_rr        <= REQ_ENG;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_vga_ack   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_eng_ack   <= 1'b0;
            r_vga_rdata <= '0;
            r_cpu_rdata <= '0;
            r_eng_rdata <= '0;
        end else begin
            // Issue stage
            r_tag_a  <= w_winner;
            r_mem_en <= (w_winner != REQ_NONE);
            r_mem_we <= w_we;
            if (w_winner != REQ_NONE) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
            end
            if (w_win_oh[1] || w_win_oh[2]) begin
                r_rr <= w_winner;
            end

            // Advance; RAM data for the tag_b access is valid now
            r_tag_b <= r_tag_a;
            r_we_b  <= r_mem_we;
            r_tag_c <= r_tag_b;

            r_vga_ack <= (r_tag_b == REQ_VGA);
            r_cpu_ack <= (r_tag_b == REQ_CPU);
            r_eng_ack <= (r_tag_b == REQ_ENG);
            if (r_tag_b == REQ_VGA && !r_we_b) r_vga_rdata <= bus.mem_rdata;
            if (r_tag_b == REQ_CPU && !r_we_b) r_cpu_rdata <= bus.mem_rdata;
            if (r_tag_b == REQ_ENG && !r_we_b) r_eng_rdata <= bus.mem_rdata;
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.vga_ack   = r_vga_ack;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.eng_ack   = r_eng_ack;
    assign bus.vga_rdata = r_vga_rdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.eng_rdata = r_eng_rdata;

`ifdef LG_ARB_PERF_EN
    // Stall = eligible at this edge but another requester was selected
    logic [C_STALL_W-1:0] r_stall [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) r_stall[i] <= '0;
        end else if (perf_clr) begin
            for (int i = 0; i < 3; i++) r_stall[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_elig[i] && !w_win_oh[i] && (r_stall[i] != '1)) begin
                    r_stall[i] <= r_stall[i] + 1'b1;
                end
            end
        end
    end

    assign vga_stall = r_stall[0];
    assign cpu_stall = r_stall[1];
    assign eng_stall = r_stall[2];
`else
    // Without the counters, the one-hot only serves the rr update
    logic w_unused_oh;
    assign w_unused_oh = w_win_oh[0];
`endif

endmodule : lg_cell_arbiter
`default_nettype wire
